// File: rtl/prefetch_pkg.sv
// Shared CPU-side types and constants for the instruction-byte prefetcher.
package prefetch_pkg;

    localparam int BYTE       = 8;
    localparam int ADDR_WIDTH = 16;

    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR = 16'hFFFC;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_VEC_LO,
        PF_VEC_HI,
        PF_STREAM
    } prefetch_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [BYTE-1:0]       data;
    } pf_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO of {addr, data} entries with a single-cycle flush.
// The head is presented from the storage registers; when empty it reads as zero.
module byte_fifo
    import prefetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush,
    input  logic          push,
    input  pf_entry_t     push_data,
    input  logic          pop,
    output pf_entry_t     head,
    output logic          empty,
    output logic [CW-1:0] count
);

    pf_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign do_pop = pop && !empty;
    assign head   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only visible through head when non-empty.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/prefetch.sv
// Instruction-byte prefetcher: fetches the reset vector, then streams
// sequential bytes into a FIFO for the fetch stage. Redirects flush the
// FIFO and discard every response still in flight.
module prefetch
    import prefetch_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [15:0] RESET_VECTOR    = RESET_VECTOR_ADDR
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic [7:0]  byte_o,
    output logic [15:0] byte_pc_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    prefetch_state_t state_q, state_d;
    logic [15:0]     pc_q;
    logic [7:0]      vec_lo_q;
    logic [OW-1:0]   outst_q;
    logic [OW-1:0]   drop_q;
    logic [15:0]     tag_q [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wr_q;
    logic [TW-1:0]   tag_rd_q;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    pf_entry_t       fifo_head;
    pf_entry_t       push_entry;
    logic            grant;
    logic            resp_stream;
    logic            redirect_act;
    logic            fifo_push;
    logic            fifo_pop;
    logic [SW-1:0]   credit_sum;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
    endfunction

    assign redirect_act = redirect_i && (state_q == PF_STREAM);
    assign grant        = mem_req_o && mem_gnt_i;
    assign resp_stream  = mem_rvalid_i && (state_q == PF_STREAM);
    assign fifo_push    = resp_stream && (drop_q == '0) && !redirect_act;
    assign fifo_pop     = !fifo_empty && byte_ready_i;
    // Occupancy plus reads in flight bounds what can still land in the FIFO.
    assign credit_sum   = SW'(fifo_count) + SW'(outst_q);
    assign push_entry   = '{addr: tag_q[tag_rd_q], data: mem_rdata_i};

    // Next state and memory request; request depends only on registers and redirect_i.
    always_comb begin
        state_d    = state_q;
        mem_req_o  = 1'b0;
        mem_addr_o = RESET_VECTOR;
        case (state_q)
            PF_IDLE: state_d = PF_VEC_LO;
            PF_VEC_LO: begin
                mem_req_o = (outst_q == '0);
                if (mem_rvalid_i) state_d = PF_VEC_HI;
            end
            PF_VEC_HI: begin
                mem_addr_o = RESET_VECTOR + 16'd1;
                mem_req_o  = (outst_q == '0);
                if (mem_rvalid_i) state_d = PF_STREAM;
            end
            PF_STREAM: begin
                mem_addr_o = pc_q;
                mem_req_o  = (credit_sum < SW'(FIFO_DEPTH)) &&
                             (outst_q < OW'(MAX_OUTSTANDING)) && !redirect_i;
            end
            default: state_d = PF_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= PF_IDLE;
        else         state_q <= state_d;
    end

    // PC: loaded from the vector, replaced on redirect, advanced on each stream grant.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q     <= '0;
            vec_lo_q <= '0;
        end else if (state_q == PF_VEC_LO && mem_rvalid_i) begin
            vec_lo_q <= mem_rdata_i;
        end else if (state_q == PF_VEC_HI && mem_rvalid_i) begin
            pc_q <= {mem_rdata_i, vec_lo_q};
        end else if (redirect_act) begin
            pc_q <= redirect_pc_i;
        end else if (grant && state_q == PF_STREAM) begin
            pc_q <= pc_q + 16'd1;
        end
    end

    // Outstanding and drop counters. On redirect every read still in flight
    // becomes stale, which already covers drops left over from an earlier redirect.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            outst_q <= outst_q + OW'(grant) - OW'(mem_rvalid_i);
            if (redirect_act)
                drop_q <= outst_q - OW'(mem_rvalid_i);
            else if (resp_stream && drop_q != '0)
                drop_q <= drop_q - OW'(1);
        end
    end

    // Tag queue pointers: push request address on grant, pop on each stream response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            if (grant && state_q == PF_STREAM) tag_wr_q <= tag_next(tag_wr_q);
            if (resp_stream)                   tag_rd_q <= tag_next(tag_rd_q);
        end
    end

    // Tag queue storage.
    always_ff @(posedge clk_i) begin
        if (grant && state_q == PF_STREAM) tag_q[tag_wr_q] <= pc_q;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .flush     (redirect_act),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign byte_valid_o = !fifo_empty;
    assign byte_o       = fifo_head.data;
    assign byte_pc_o    = fifo_head.addr;

endmodule

// File: tb/tb_prefetch.sv
// Testbench for prefetch: behavioural memory with programmable latency and
// grant stall, and a scoreboard of expected byte addresses.
module tb_prefetch;

    logic        clk;
    logic        rstn_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [7:0]  byte_o;
    logic [15:0] byte_pc_o;
    logic        byte_valid_o;
    logic        byte_ready_i;

    prefetch #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_VECTOR    (16'hFFFC)
    ) u_dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .byte_o        (byte_o),
        .byte_pc_o     (byte_pc_o),
        .byte_valid_o  (byte_valid_o),
        .byte_ready_i  (byte_ready_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_xfer = 0;
    int lat;
    logic gnt_en;

    typedef struct {
        logic [15:0] a;
        int          due;
    } req_t;
    req_t        pend[$];
    req_t        r;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    logic [15:0] a0;
    int          n0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'hFFFC) return 8'h00;
        if (a == 16'hFFFD) return 8'h80;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic expect_from(input logic [15:0] base);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(16'(base + i));
    endtask

    task automatic wait_xfers(input int n, input int limit);
        int target;
        target = n_xfer + n;
        for (int i = 0; i < limit && n_xfer < target; i++) begin
            @(negedge clk);
            #3;
        end
        chk("xfer_progress", n_xfer, target);
    endtask

    task automatic do_redirect(input logic [15:0] pc, input bit check_timing);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        expect_from(pc);
        @(negedge clk);
        redirect_i = 1'b0;
        if (check_timing) begin
            #3;
            chk("redir_valid", byte_valid_o, 0);
            chk("redir_req", mem_req_o, 1);
            chk("redir_addr", mem_addr_o, pc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   mem_req_o, 0);
        chk({tag, "_addr"},  mem_addr_o, 16'hFFFC);
        chk({tag, "_valid"}, byte_valid_o, 0);
        chk({tag, "_byte"},  byte_o, 0);
        chk({tag, "_pc"},    byte_pc_o, 0);
    endtask

    // Memory: grant decided after inputs settle, in-order responses after lat cycles.
    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = 8'h00;
            if (!rstn_i) begin
                pend.delete();
                mem_gnt_i = 1'b0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    r = pend.pop_front();
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_byte(r.a);
                end
                mem_gnt_i = gnt_en && mem_req_o;
                if (mem_gnt_i) pend.push_back('{mem_addr_o, cyc + lat});
            end
        end
    end

    // Monitor: every accepted byte must be the next expected address with its data.
    initial forever begin
        @(negedge clk);
        #2;
        if (rstn_i && byte_valid_o && byte_ready_i && !redirect_i) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("extra_byte", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("byte_pc", byte_pc_o, mon_e);
                chk("byte_data", byte_o, mem_byte(mon_e));
            end
        end
    end

    initial begin
        rstn_i        = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 16'h0000;
        byte_ready_i  = 1'b1;
        gnt_en        = 1'b1;
        lat           = 1;
        #2 rstn_i = 1'b0;

        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs("rst");

        // Reset vector fetch and sequential stream from $8000
        expect_from(16'h8000);
        @(negedge clk);
        rstn_i = 1'b1;
        wait_xfers(4, 40);

        // Steady-state throughput with 1-cycle memory
        n0 = n_xfer;
        repeat (16) @(negedge clk);
        #3;
        chk("rate", n_xfer - n0, 16);

        // Backpressure
        @(negedge clk);
        byte_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        chk("bp_req", mem_req_o, 0);
        chk("bp_valid", byte_valid_o, 1);
        chk("bp_count", u_dut.u_fifo.count_q, 4);
        @(negedge clk);
        byte_ready_i = 1'b1;
        wait_xfers(8, 40);

        // Address wrap through $FFFF
        do_redirect(16'hFFFE, 1'b1);
        wait_xfers(5, 40);

        // Grant stall: address and PC hold
        @(negedge clk);
        #3;
        a0 = mem_addr_o + 16'd1;
        chk("pre_stall_req", mem_req_o, 1);
        @(negedge clk);
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("stall_addr", mem_addr_o, a0);
            chk("stall_pc", u_dut.pc_q, a0);
            @(negedge clk);
        end
        gnt_en = 1'b1;
        wait_xfers(6, 40);

        // Redirect with two reads in flight (3-cycle latency)
        @(negedge clk);
        lat = 3;
        wait_xfers(6, 80);
        do_redirect(16'hC000, 1'b0);
        wait_xfers(4, 60);

        // Back-to-back redirects coinciding with responses
        @(negedge clk);
        lat = 1;
        wait_xfers(6, 60);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h9000;
        expect_from(16'h9000);
        @(negedge clk);
        redirect_pc_i = 16'hA000;
        expect_from(16'hA000);
        @(negedge clk);
        redirect_i = 1'b0;
        wait_xfers(6, 60);

        // Asynchronous reset mid-stream
        @(posedge clk);
        #2 rstn_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        expect_from(16'h8000);
        repeat (2) @(negedge clk);
        rstn_i = 1'b1;
        wait_xfers(5, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
